// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with PC, 2-entry fetch queue, redirect and halt
module inst_fetch_ctrl #(
  parameter int              AW         = 8,
  parameter int              DW         = 16,
  parameter logic [AW-1:0]   RESET_PC   = '0,
  parameter logic [DW-1:0]   HALT_INSTR = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  output logic          halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    count_q, count_d;
  // ent0 is always the queue head; ent1 only holds data when count_q == 2
  logic [DW-1:0] ent0_data_q, ent0_data_d;
  logic [AW-1:0] ent0_pc_q, ent0_pc_d;
  logic [DW-1:0] ent1_data_q, ent1_data_d;
  logic [AW-1:0] ent1_pc_q, ent1_pc_d;

  logic pop;
  logic fetch;

  // Every output is a flop, so inst_ready/redirect_valid never reach them combinationally
  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst_data  = ent0_data_q;
  assign inst_pc    = ent0_pc_q;
  assign halted     = (state_q == ST_HALT);

  assign pop   = inst_valid & inst_ready;
  assign fetch = (state_q == ST_RUN) & en & ~redirect_valid & ((count_q < 2'd2) | pop);

  // Next-state: redirect flushes and retargets; otherwise push the fetched word and/or pop the head
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    ent0_data_d = ent0_data_q;
    ent0_pc_d   = ent0_pc_q;
    ent1_data_d = ent1_data_q;
    ent1_pc_d   = ent1_pc_q;

    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else begin
      if (fetch) begin
        pc_d = pc_q + AW'(1);
        if (imem_data == HALT_INSTR) begin
          state_d = ST_HALT;
        end
      end

      case ({pop, fetch})
        2'b01: begin
          if (count_q == 2'd0) begin
            ent0_data_d = imem_data;
            ent0_pc_d   = pc_q;
          end else begin
            ent1_data_d = imem_data;
            ent1_pc_d   = pc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b10: begin
          ent0_data_d = ent1_data_q;
          ent0_pc_d   = ent1_pc_q;
          count_d     = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_data_d = imem_data;
            ent0_pc_d   = pc_q;
          end else begin
            ent0_data_d = ent1_data_q;
            ent0_pc_d   = ent1_pc_q;
            ent1_data_d = imem_data;
            ent1_pc_d   = pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State, PC and queue registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      ent0_data_q <= '0;
      ent0_pc_q   <= '0;
      ent1_data_q <= '0;
      ent1_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      ent0_data_q <= ent0_data_d;
      ent0_pc_q   <= ent0_pc_d;
      ent1_data_q <= ent1_data_d;
      ent1_pc_q   <= ent1_pc_d;
    end
  end

endmodule
